// File: rtl/led_fade_ramp_pkg.sv
// rtl/led_fade_ramp_pkg.sv - shared state encoding, output width and gamma map for led_fade_ramp (FADE_GAMMA_EN)
package led_fade_ramp_pkg;

  localparam int OUT_W = 8;

  typedef enum logic [1:0] {
    ST_RISE      = 2'd0,
    ST_HOLD_HIGH = 2'd1,
    ST_FALL      = 2'd2,
    ST_HOLD_LOW  = 2'd3
  } fade_state_t;

  // ((v+1)^2 - 1) >> 8 rewritten as v*(v+2) >> 8, which fits 16 bits exactly (255*257 = 65535)
  function automatic logic [OUT_W-1:0] gamma_map(input logic [OUT_W-1:0] v);
    logic [15:0] p;
    p = {8'd0, v} * ({8'd0, v} + 16'd2);
    return OUT_W'(p >> 8);
  endfunction

endpackage

// File: rtl/fade_gamma.sv
// rtl/fade_gamma.sv - perceptual squared brightness map, exists only when FADE_GAMMA_EN is defined
`ifdef FADE_GAMMA_EN
module fade_gamma
  import led_fade_ramp_pkg::*;
(
  input  logic [OUT_W-1:0] i_value,
  output logic [OUT_W-1:0] o_value
);

  // purely combinational; the caller registers the result
  always_comb begin
    o_value = gamma_map(i_value);
  end

endmodule
`endif

// File: rtl/led_fade_ramp.sv
// rtl/led_fade_ramp.sv - breathing duty-value sweep for pwm8b; FADE_GAMMA_EN selects the squared output map
module led_fade_ramp
  import led_fade_ramp_pkg::*;
#(
  parameter int STEP_DIV   = 50000,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 255,
  parameter int STEP       = 1,
  parameter int HOLD_STEPS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [OUT_W-1:0] value_out,
  output logic             strobe
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(STEP_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [8:0] MIN9  = 9'(MIN_VAL);
  localparam logic [8:0] MAX9  = 9'(MAX_VAL);
  localparam logic [8:0] STEP9 = 9'(STEP);

  logic [CW-1:0]    r_cnt;
  logic [HW-1:0]    r_hold;
  logic [OUT_W-1:0] r_level;
  fade_state_t      r_state;
  logic             r_upd;

  logic             w_tick;
  logic [8:0]       w_sum;
  logic [8:0]       w_diff;
  logic             w_under;
  logic [OUT_W-1:0] w_map;

  assign w_tick  = en && (r_cnt == CNT_LAST);
  assign w_sum   = {1'b0, r_level} + STEP9;
  assign w_diff  = {1'b0, r_level} - STEP9;
  assign w_under = w_diff[8];

`ifdef FADE_GAMMA_EN
  localparam logic [OUT_W-1:0] RST_OUT = gamma_map(OUT_W'(MIN_VAL));
  fade_gamma u_gamma (
    .i_value (r_level),
    .o_value (w_map)
  );
`else
  localparam logic [OUT_W-1:0] RST_OUT = OUT_W'(MIN_VAL);
  assign w_map = r_level;
`endif

  // prescaler: counts enabled cycles, wraps on the tick, frozen while en is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // sweep FSM: level, state and dwell counter move only on a tick; r_upd flags a level move
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RISE;
      r_level <= OUT_W'(MIN_VAL);
      r_hold  <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_upd <= w_tick && ((r_state == ST_RISE) || (r_state == ST_FALL));
      if (w_tick) begin
        case (r_state)
          ST_RISE: begin
            if (w_sum >= MAX9) begin
              r_level <= MAX9[7:0];
              r_hold  <= '0;
              r_state <= (HOLD_STEPS == 0) ? ST_FALL : ST_HOLD_HIGH;
            end else begin
              r_level <= w_sum[7:0];
            end
          end
          ST_HOLD_HIGH: begin
            if (r_hold == HOLD_LAST) begin
              r_hold  <= '0;
              r_state <= ST_FALL;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
          ST_FALL: begin
            if (w_under || (w_diff <= MIN9)) begin
              r_level <= MIN9[7:0];
              r_hold  <= '0;
              r_state <= (HOLD_STEPS == 0) ? ST_RISE : ST_HOLD_LOW;
            end else begin
              r_level <= w_diff[7:0];
            end
          end
          default: begin
            if (r_hold == HOLD_LAST) begin
              r_hold  <= '0;
              r_state <= ST_RISE;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // output stage: mapped level one cycle after it moves, strobe marks the new value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_out <= RST_OUT;
      strobe    <= 1'b0;
    end else begin
      value_out <= w_map;
      strobe    <= r_upd;
    end
  end

endmodule
